// File: rtl/bsr_scan_arbiter.sv
// bsr_scan_arbiter: shares the boundary-scan register chain between the
// external TAP and an internal self-test requester. For self-test it runs a
// capture / shift / update pass itself and returns the captured pin values.
// Optional feature: define BSR_ARB_PREEMPT_EN to let the TAP preempt a
// self-test pass in progress; otherwise the TAP waits for the pass to finish.
module bsr_scan_arbiter #(
  parameter int LEN = 4
) (
  input  logic           clkDR,
  input  logic           reset,
  input  logic           tap_active,
  input  logic           tap_capture,
  input  logic           tap_shift,
  input  logic           tap_update,
  input  logic           tap_mode,
  input  logic           tap_tdi,
  output logic           tap_tdo,
  output logic           tap_wait,
  input  logic           bist_req,
  input  logic [LEN-1:0] bist_pattern,
  output logic           bist_ack,
  output logic           bist_abort,
  output logic           bist_busy,
  output logic [LEN-1:0] bist_result,
  output logic           bsr_enableIn,
  output logic           bsr_enableOut,
  output logic           bsr_mode,
  output logic           bsr_shiftDR,
  output logic           bsr_updateDR,
  output logic           bsr_tdi,
  input  logic           bsr_tdo,
  output logic [1:0]     owner
);

  localparam int CW = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LEN-1:0]  pat_q, pat_d;
  logic [LEN-1:0]  res_q, res_d;
  logic            sample;
  logic [CW-1:0]   tdi_idx;

`ifdef BSR_ARB_PREEMPT_EN
  logic            abort_q, abort_d;
  logic            preempt;

  // The TAP may take the chain back from any running self-test phase.
  assign preempt = tap_active && (state_q != IDLE) && (state_q != DONE);
`endif

  // Captured data leaves the chain on CAPTURE and every shift but the last.
  assign sample  = (state_q == CAPTURE) || ((state_q == SHIFT) && (cnt_q != LAST));
  // Pattern goes out MSB first: shift k drives pattern[LEN-1-k].
  assign tdi_idx = LAST - cnt_q;

  // Next-state, counter, pattern latch and result shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    res_d   = res_q;
    if (sample) begin
      res_d = {res_q[LEN-2:0], bsr_tdo};
    end
    case (state_q)
      IDLE: begin
        // TAP wins a tie with a self-test request.
        if (bist_req && !tap_active) begin
          pat_d   = bist_pattern;
          cnt_d   = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == LAST) begin
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UPDATE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef BSR_ARB_PREEMPT_EN
    if (preempt) begin
      state_d = DONE;
    end
    // Abort flag lives exactly for the DONE cycle that follows a preemption.
    abort_d = preempt || (abort_q && (state_q != DONE));
`endif
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clkDR or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      res_q   <= '0;
`ifdef BSR_ARB_PREEMPT_EN
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      res_q   <= res_d;
`ifdef BSR_ARB_PREEMPT_EN
      abort_q <= abort_d;
`endif
    end
  end

  assign bist_result = res_q;

  // Ownership decode and chain control mux; everything is held at 0 in reset.
  always_comb begin
    owner         = 2'b00;
    tap_tdo       = 1'b0;
    tap_wait      = 1'b0;
    bist_ack      = 1'b0;
    bist_abort    = 1'b0;
    bist_busy     = 1'b0;
    bsr_enableIn  = 1'b0;
    bsr_enableOut = 1'b0;
    bsr_mode      = 1'b0;
    bsr_shiftDR   = 1'b0;
    bsr_updateDR  = 1'b0;
    bsr_tdi       = 1'b0;
    if (!reset) begin
      bist_busy = (state_q != IDLE);
`ifndef BSR_ARB_PREEMPT_EN
      tap_wait  = tap_active && (state_q != IDLE);
`endif
      case (state_q)
        IDLE: begin
          if (tap_active) begin
            owner         = 2'b01;
            tap_tdo       = bsr_tdo;
            bsr_enableIn  = tap_capture;
            bsr_enableOut = 1'b1;
            bsr_mode      = tap_mode;
            bsr_shiftDR   = tap_shift;
            bsr_updateDR  = tap_update;
            bsr_tdi       = tap_tdi;
          end else begin
            bsr_mode = tap_mode;
          end
        end
        CAPTURE: begin
          owner        = 2'b10;
          bsr_enableIn = 1'b1;
        end
        SHIFT: begin
          owner       = 2'b10;
          bsr_shiftDR = 1'b1;
          bsr_tdi     = pat_q[tdi_idx];
        end
        UPDATE: begin
          owner         = 2'b10;
          bsr_updateDR  = 1'b1;
          bsr_mode      = 1'b1;
          bsr_enableOut = 1'b1;
        end
        DONE: begin
          owner         = 2'b10;
          bsr_mode      = 1'b1;
          bsr_enableOut = 1'b1;
          bist_ack      = 1'b1;
`ifdef BSR_ARB_PREEMPT_EN
          bist_abort    = abort_q;
`endif
        end
        default: begin
          owner = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsr_scan_arbiter.sv
// Testbench for bsr_scan_arbiter: directed scenarios followed by randomized
// traffic, checked every cycle against a phase-based behavioural model. A
// small bsreg chain model supplies bsr_tdo and the update latches.
module tb_bsr_scan_arbiter;

  localparam int LEN = 4;

  logic           clkDR = 1'b0;
  logic           reset;
  logic           tap_active, tap_capture, tap_shift, tap_update, tap_mode, tap_tdi;
  logic           tap_tdo, tap_wait;
  logic           bist_req;
  logic [LEN-1:0] bist_pattern;
  logic           bist_ack, bist_abort, bist_busy;
  logic [LEN-1:0] bist_result;
  logic           bsr_enableIn, bsr_enableOut, bsr_mode, bsr_shiftDR, bsr_updateDR, bsr_tdi;
  logic           bsr_tdo;
  logic [1:0]     owner;

  always #5 clkDR = ~clkDR;

  bsr_scan_arbiter #(.LEN(LEN)) dut (
    .clkDR(clkDR), .reset(reset),
    .tap_active(tap_active), .tap_capture(tap_capture), .tap_shift(tap_shift),
    .tap_update(tap_update), .tap_mode(tap_mode), .tap_tdi(tap_tdi),
    .tap_tdo(tap_tdo), .tap_wait(tap_wait),
    .bist_req(bist_req), .bist_pattern(bist_pattern), .bist_ack(bist_ack),
    .bist_abort(bist_abort), .bist_busy(bist_busy), .bist_result(bist_result),
    .bsr_enableIn(bsr_enableIn), .bsr_enableOut(bsr_enableOut), .bsr_mode(bsr_mode),
    .bsr_shiftDR(bsr_shiftDR), .bsr_updateDR(bsr_updateDR), .bsr_tdi(bsr_tdi),
    .bsr_tdo(bsr_tdo), .owner(owner)
  );

  // bsreg chain model: tdi -> cell 0 -> ... -> cell LEN-1 -> tdo, acting on the falling edge.
  logic [LEN-1:0] cells = '0;
  logic [LEN-1:0] upd   = '0;
  logic [LEN-1:0] pin   = '0;
  always @(negedge clkDR) begin
    if (bsr_shiftDR)       cells <= {cells[LEN-2:0], bsr_tdi};
    else if (bsr_enableIn) cells <= pin;
    if (bsr_updateDR)      upd <= cells;
  end
  assign bsr_tdo = cells[LEN-1];

  // Reference model: ph = -1 idle, 0 capture, 1..LEN shift (k = ph-1),
  // LEN+1 update, LEN+2 done. Result after m samples is the old result shifted
  // left by m with the top m captured pins filling the bottom.
  int             ph = -1;
  bit             ab = 0;
  logic [LEN-1:0] pm = '0;
  logic [31:0]    base = '0, pinm = '0;
  int             m = 0;
  logic [LEN-1:0] res_m = '0;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = -1; ab = 0; m = 0; base = '0; pinm = '0; res_m = '0;
  endtask

  task automatic model_edge();
    bit pre;
    if (ph == -1) begin
      if (!tap_active && bist_req) begin
        ph = 0; pm = bist_pattern; base = 32'(res_m); pinm = 32'(pin); m = 0; ab = 0;
      end
    end else begin
      if (ph >= 0 && ph <= LEN - 1) begin
        m++;
        res_m = LEN'((base << m) | (pinm >> (LEN - m)));
      end
      pre = 1'b0;
`ifdef BSR_ARB_PREEMPT_EN
      pre = tap_active && (ph != LEN + 2);
`endif
      if (pre) begin
        ph = LEN + 2; ab = 1;
      end else if (ph == LEN + 2) begin
        ph = -1; ab = 0;
      end else begin
        ph++;
      end
    end
  endtask

  task automatic check_all();
    logic [1:0]     e_own;
    logic           e_busy, e_ack, e_abt, e_wt, e_tdo;
    logic [5:0]     e_bsr;
    e_own = 2'b00; e_busy = 0; e_ack = 0; e_abt = 0; e_wt = 0; e_tdo = 0; e_bsr = '0;
    if (!reset) begin
      if (ph == -1) begin
        if (tap_active) begin
          e_own = 2'b01;
          e_tdo = cells[LEN-1];
          e_bsr = {tap_capture, 1'b1, tap_mode, tap_shift, tap_update, tap_tdi};
        end else begin
          e_bsr = {2'b00, tap_mode, 3'b000};
        end
      end else begin
        e_own  = 2'b10;
        e_busy = 1'b1;
`ifndef BSR_ARB_PREEMPT_EN
        e_wt   = tap_active;
`endif
        if (ph == 0)             e_bsr = 6'b100000;
        else if (ph <= LEN)      e_bsr = {5'b00010, pm[LEN-ph]};
        else if (ph == LEN + 1)  e_bsr = 6'b011010;
        else begin
          e_bsr = 6'b011000; e_ack = 1'b1; e_abt = ab;
        end
      end
    end
    chk("owner",  64'(owner), 64'(e_own));
    chk("busy",   64'(bist_busy), 64'(e_busy));
    chk("ack",    64'(bist_ack), 64'(e_ack));
    chk("abort",  64'(bist_abort), 64'(e_abt));
    chk("wait",   64'(tap_wait), 64'(e_wt));
    chk("tap_tdo", 64'(tap_tdo), 64'(e_tdo));
    chk("bsr_ctl", 64'({bsr_enableIn, bsr_enableOut, bsr_mode, bsr_shiftDR, bsr_updateDR, bsr_tdi}),
        64'(e_bsr));
    chk("result", 64'(bist_result), 64'(res_m));
  endtask

  task automatic do_edge();
    @(posedge clkDR);
    #1;
    model_edge();
  endtask

  task automatic settle_check();
    #1;
    check_all();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    reset = 1'b0;
  endtask

  initial begin : stim
    int n;
    logic [3:0] tdo_seq;
    logic [3:0] shin;
    reset = 1'b1;
    tap_active = 0; tap_capture = 0; tap_shift = 0; tap_update = 0; tap_mode = 0; tap_tdi = 0;
    bist_req = 0; bist_pattern = '0;
    #12;
    model_reset();
    check_all();
    chk("reset_owner", 64'(owner), 64'(2'b00));
    reset = 1'b0;

    // Self-test pass with known pins and pattern.
    do_edge();
    pin = 4'b1010; bist_pattern = 4'b0110; bist_req = 1'b1;
    settle_check();
    do_edge();
    settle_check();
    n = 0;
    while (n < 20) begin
      do_edge(); n++;
      settle_check();
      if (bist_ack) break;
    end
    chk("st_latency", 64'(n), 64'd6);
    chk("st_result", 64'(bist_result), 64'(4'b1010));
    chk("st_abort", 64'(bist_abort), 64'd0);
    chk("st_pout", 64'(upd), 64'(4'b0110));
    bist_req = 1'b0;
    do_edge(); settle_check();

    // TAP passthrough: capture pins 0011, then shift 1,0,0,1 in.
    tap_active = 1'b1; tap_capture = 1'b1; pin = 4'b0011;
    settle_check();
    chk("tap_owner", 64'(owner), 64'(2'b01));
    tdo_seq = 4'b1100;
    shin    = 4'b1001;
    for (int j = 0; j < 4; j++) begin
      do_edge();
      tap_capture = 1'b0; tap_shift = 1'b1; tap_tdi = shin[3-j];
      settle_check();
      chk("tap_shift", 64'(bsr_shiftDR), 64'd1);
      chk("tap_tdo_seq", 64'(tap_tdo), 64'(tdo_seq[j]));
    end
    do_edge();
    tap_shift = 1'b0; tap_update = 1'b1; tap_mode = 1'b1;
    settle_check();
    do_edge();
    tap_update = 1'b0; tap_mode = 1'b0;
    settle_check();

    // Simultaneous request: TAP keeps the chain, self-test waits.
    bist_req = 1'b1; bist_pattern = 4'b1100;
    settle_check();
    for (int j = 0; j < 3; j++) begin
      do_edge(); settle_check();
      chk("sim_owner", 64'(owner), 64'(2'b01));
      chk("sim_busy", 64'(bist_busy), 64'd0);
    end
    do_edge();
    tap_active = 1'b0;
    settle_check();
    do_edge(); settle_check();
    chk("sim_accept", 64'(bist_busy), 64'd1);
    n = 0;
    while (n < 20 && !bist_ack) begin
      do_edge(); n++; settle_check();
    end
    bist_req = 1'b0;
    do_edge(); settle_check();

    // TAP arrives at SHIFT k=1 of a pass.
    bist_req = 1'b1; bist_pattern = 4'b0101; pin = 4'b1110;
    settle_check();
    do_edge(); settle_check();
    do_edge(); settle_check();
    do_edge();
    tap_active = 1'b1;
    settle_check();
`ifdef BSR_ARB_PREEMPT_EN
    chk("pre_wait", 64'(tap_wait), 64'd0);
    do_edge(); settle_check();
    chk("pre_ack", 64'(bist_ack), 64'd1);
    chk("pre_abort", 64'(bist_abort), 64'd1);
    chk("pre_noupd", 64'(bsr_updateDR), 64'd0);
    bist_req = 1'b0;
    do_edge(); settle_check();
    chk("pre_owner", 64'(owner), 64'(2'b01));
`else
    chk("np_wait", 64'(tap_wait), 64'd1);
    n = 0;
    while (n < 20) begin
      do_edge(); n++; settle_check();
      if (bist_ack) break;
    end
    chk("np_latency", 64'(n), 64'd4);
    chk("np_abort", 64'(bist_abort), 64'd0);
    chk("np_pout", 64'(upd), 64'(4'b0101));
    bist_req = 1'b0;
    do_edge(); settle_check();
    chk("np_owner", 64'(owner), 64'(2'b01));
`endif
    tap_active = 1'b0;
    do_edge(); settle_check();

    // Reset in the middle of SHIFT.
    bist_req = 1'b1;
    settle_check();
    do_edge(); settle_check();
    do_edge(); settle_check();
    do_edge(); settle_check();
    bist_req = 1'b0;
    reset_pulse();
    chk("rst_owner", 64'(owner), 64'(2'b00));
    chk("rst_busy", 64'(bist_busy), 64'd0);
    chk("rst_result", 64'(bist_result), 64'd0);

    // Randomized traffic.
    for (int it = 0; it < 2000; it++) begin
      do_edge();
      if ($urandom_range(0, 11) == 0) tap_active = ~tap_active;
      tap_capture = 1'($urandom); tap_shift = 1'($urandom); tap_update = 1'($urandom);
      tap_mode = 1'($urandom); tap_tdi = 1'($urandom);
      if (ph == -1) begin
        bist_req = ($urandom_range(0, 3) != 0);
        bist_pattern = LEN'($urandom);
        pin = LEN'($urandom);
      end else if (ph == LEN + 2) begin
        bist_req = 1'($urandom);
      end
      settle_check();
      if ($urandom_range(0, 199) == 0) reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bsr_scan_arbiter.md
# bsr_scan_arbiter

Arbiter and sequencer for the boundary-scan register chain (`bsreg`). It shares the chain between two requesters:
- the external TAP, which drives the DR phase strobes directly;
- an internal self-test requester, which asks for one complete capture/shift/update pass with a supplied pattern.

For self-test it runs the capture-shift-update sequence itself and returns the captured pin values.

## Interface
- `LEN`, default 4: boundary-scan chain length in cells. It must equal the `len` of the attached `bsreg`. `LEN >= 2`.
- `clkDR` in 1: DR clock, rising-edge; `bsreg` cells act on the falling edge.
- `reset` in 1: asynchronous, active-high.
- `tap_active` in 1: TAP has selected the BSR in a DR state; this is the TAP's ownership request.
- `tap_capture` / `tap_shift` / `tap_update` in 1 each: TAP strobes, passed to the chain when the TAP owns it.
- `tap_mode` in 1: TAP mode bit (EXTEST/INTEST = 1), passed through when the TAP owns the chain.
- `tap_tdi` in 1: TAP serial in.
- `tap_tdo` out 1: chain serial out, returned to the TAP; forced to 0 when the TAP is not the owner.
- `tap_wait` out 1: TAP request pending but blocked by self-test (only when preemption is off).
- `bist_req` in 1: self-test request, level; held until `bist_ack`.
- `bist_pattern` in `LEN`: pattern to load into cells `[LEN-1:0]`; latched on accept.
- `bist_ack` out 1: one-cycle pulse at the end of a self-test pass.
- `bist_abort` out 1: valid with `bist_ack`; 1 = pass was preempted.
- `bist_busy` out 1: high from accept until `bist_ack`.
- `bist_result` out `LEN`: captured `data_pin` values; `bist_result[i]` = cell i.
- `bsr_enableIn`, `bsr_enableOut`, `bsr_mode`, `bsr_shiftDR`, `bsr_updateDR`, `bsr_tdi` out 1 each: chain controls.
- `bsr_tdo` in 1: chain serial out.
- `owner` out 2: `00` none, `01` TAP, `10` self-test.

## Operation
- **FSM states:** IDLE, CAPTURE, SHIFT, UPDATE, DONE.
- **Reset:** all outputs are 0 on reset, with these register values:
  - state = IDLE;
  - bit counter = 0;
  - `bist_result` = 0;
  - pattern latch = 0.
- **TAP ownership:**
  - Combinational: `owner` = `01` while state = IDLE and `tap_active` = 1.
  - The TAP has priority over a simultaneous `bist_req`.
  - While the TAP owns the chain, every `bsr_*` output equals its matching `tap_*` input, with these exceptions:
    - `bsr_enableIn` = `tap_capture`;
    - `bsr_enableOut` = 1;
    - `bsr_tdi` = `tap_tdi`.
  - While the TAP owns the chain, `tap_tdo` = `bsr_tdo`.
- **Idle:** with no owner, all `bsr_*` outputs are 0 and `bsr_mode` = `tap_mode`.
- **Accept:** in IDLE with `bist_req` = 1 and `tap_active` = 0:
  - latch `bist_pattern`;
  - clear the counter;
  - go to CAPTURE;
  - set `bist_busy`.
  
  `owner` = `10` from CAPTURE through DONE.
- **CAPTURE (1 cycle):** `bsr_enableIn` = 1, `bsr_shiftDR` = 0. At the end-of-cycle rising edge, sample `bsr_tdo` into `bist_result`, shifting in at the LSB.
- **SHIFT (`LEN` cycles, counter k = 0..LEN-1):**
  - `bsr_shiftDR` = 1;
  - `bsr_tdi` = `pattern[LEN-1-k]` (MSB first);
  - for k < LEN-1, sample `bsr_tdo` into `bist_result` (LSB shift-in) at the end of the cycle.
  
  After `LEN` samples, `bist_result[i]` holds cell i's captured value. At k = LEN-1, go to UPDATE.
- **UPDATE (1 cycle):** `bsr_updateDR` = 1, `bsr_mode` = 1, `bsr_enableOut` = 1. Cell i now drives `pattern[i]`.
- **DONE (1 cycle):**
  - `bist_ack` = 1, `bist_abort` = 0;
  - `bsr_mode` = 1, `bsr_enableOut` = 1;
  - go to IDLE, where `bist_busy` drops.
  
  `bist_result` holds until the next accept.
- **Wrap:** the counter is `$clog2(LEN)` bits wide and never wraps; SHIFT exits when it equals `LEN-1`.
- **Reset mid-pass:** asynchronous return to IDLE. No `bist_ack` is issued; the requester sees `bist_busy` fall.

## Timing
- All state changes on the rising edge of `clkDR`.
- `bsr_*` controls from the FSM are registered-state decodes, stable across the falling edge at which the cells act.
- Self-test pass latency from accept edge to `bist_ack` high: `LEN`+2 cycles (CAPTURE 1, SHIFT `LEN`, UPDATE 1), with `bist_ack` asserted during cycle `LEN`+3.
- `bist_req` held high after `bist_ack` starts a new pass: it is re-accepted on the first IDLE cycle, one cycle after DONE.
- TAP passthrough is combinational; zero latency.

## Configuration
- **`BSR_ARB_PREEMPT_EN` defined:**
  - `tap_active` = 1 in any non-IDLE state forces state to DONE at the next edge, with `bist_abort` = 1 and `bist_ack` = 1, and `bsr_updateDR` held at 0.
  - During that DONE cycle `owner` = `10`.
  - The TAP gains ownership in the following IDLE cycle.
  - `tap_wait` is tied to 0.
- **`BSR_ARB_PREEMPT_EN` undefined:**
  - A self-test pass always completes.
  - `tap_wait` = `tap_active` AND state != IDLE.
  - TAP strobes are ignored while waiting.
  - `bist_abort` is tied to 0.

## Test plan
- **Reset:** assert `reset` mid-SHIFT -> all outputs 0, `owner` = `00`, `bist_busy` = 0 immediately (asynchronous).
- **Self-test, `LEN` = 4:** `data_pin` = `4'b1010`, `bist_pattern` = `4'b0110`, `bist_req` = 1 -> `bist_ack` after 6 cycles, `bist_result` = `4'b1010`, `data_pout` = `4'b0110`, `bist_abort` = 0.
- **TAP passthrough:** `tap_active` = 1, shift 4 bits `1,0,0,1` on `tap_tdi` -> `owner` = `01`; `bsr_shiftDR` follows `tap_shift`; `tap_tdo` returns the captured bits.
- **Simultaneous request:** `tap_active` = 1 and `bist_req` = 1 in the same IDLE cycle -> `owner` = `01`, `bist_busy` stays 0 until `tap_active` drops.
- **Preemption, macro defined:** `tap_active` = 1 at SHIFT k = 1 -> next cycle DONE with `bist_ack` = 1, `bist_abort` = 1, no `bsr_updateDR` pulse; `owner` = `01` one cycle later.
- **No preemption, macro undefined:** same stimulus -> `tap_wait` = 1 until DONE, the pass completes with `bist_abort` = 0, and TAP ownership is granted the cycle after DONE.
